// File: rtl/keypoint_scan_ctrl.sv
// Raster-scan controller for SIFT keypoint detection over N_SCALE DoG scales.
// Walks interior rows/columns, strobes the line buffer and stores per-scale keypoints.
module keypoint_scan_ctrl #(
    parameter int IMG_W    = 640,
    parameter int IMG_H    = 480,
    parameter int N_SCALE  = 2,
    parameter int KP_DEPTH = 2048,
    parameter int ROW_W    = 9,
    parameter int COL_W    = 10,
    parameter int KP_AW    = 11
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         abort,
    output logic                         busy,
    output logic                         done,
    output logic [ROW_W-1:0]             row_addr,
    output logic                         buffer_we,
    output logic [COL_W-1:0]             cur_col,
    input  logic [N_SCALE-1:0]           detect_hit,
    input  logic [N_SCALE-1:0]           filter_ok,
    output logic [N_SCALE-1:0]           kp_we,
    output logic [N_SCALE*KP_AW-1:0]     kp_addr,
    output logic [ROW_W+COL_W-1:0]       kp_din,
    output logic [N_SCALE*(KP_AW+1)-1:0] kp_count,
    output logic [N_SCALE-1:0]           kp_ovf
);

    typedef enum logic [2:0] {
        S_IDLE, S_PRIME, S_DETECT, S_FILTER, S_UPDATE, S_BUFFER, S_DONE
    } state_t;

    localparam logic [COL_W-1:0] COL_FIRST = COL_W'(1);
    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_W - 2);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_H - 1);
    localparam logic [KP_AW:0]   KP_FULL   = (KP_AW+1)'(KP_DEPTH);

    state_t             state, state_nxt;
    logic [N_SCALE-1:0] hit_q;
    logic [KP_AW:0]     cnt [N_SCALE];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_PRIME;
            // row_addr doubles as the prime counter: two shifts, rows 0 and 1
            S_PRIME:  if (row_addr == ROW_W'(1)) state_nxt = S_DETECT;
            S_DETECT: begin
                if (|detect_hit)              state_nxt = S_FILTER;
                else if (cur_col == COL_LAST) state_nxt = S_UPDATE;
            end
            S_FILTER: state_nxt = (cur_col == COL_LAST) ? S_UPDATE : S_DETECT;
            S_UPDATE: state_nxt = (row_addr == ROW_LAST) ? S_DONE : S_BUFFER;
            S_BUFFER: state_nxt = S_DETECT;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
        if (abort) state_nxt = S_IDLE;
    end

    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE) && !abort;
    assign buffer_we = (state == S_PRIME) || (state == S_BUFFER);

    always_comb begin
        kp_count = '0;
        for (int unsigned s = 0; s < N_SCALE; s++)
            kp_count[s*(KP_AW+1) +: (KP_AW+1)] = cnt[s];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_addr <= '0;
            cur_col  <= COL_FIRST;
            hit_q    <= '0;
            kp_we    <= '0;
            kp_addr  <= '0;
            kp_din   <= '0;
            kp_ovf   <= '0;
            for (int unsigned s = 0; s < N_SCALE; s++) cnt[s] <= '0;
        end else begin
            kp_we <= '0;
            if (abort) begin
                // counts and overflow flags survive an abort for inspection
                if (state != S_IDLE) begin
                    row_addr <= '0;
                    cur_col  <= COL_FIRST;
                end
            end else begin
                case (state)
                    S_IDLE: if (start) begin
                        row_addr <= '0;
                        cur_col  <= COL_FIRST;
                        kp_ovf   <= '0;
                        for (int unsigned s = 0; s < N_SCALE; s++) cnt[s] <= '0;
                    end
                    S_PRIME: row_addr <= row_addr + ROW_W'(1);
                    S_DETECT: begin
                        if (|detect_hit)            hit_q   <= detect_hit;
                        else if (cur_col != COL_LAST) cur_col <= cur_col + COL_W'(1);
                    end
                    S_FILTER: begin
                        kp_din <= {ROW_W'(row_addr - ROW_W'(1)), cur_col};
                        for (int unsigned s = 0; s < N_SCALE; s++) begin
                            if (hit_q[s] && filter_ok[s]) begin
                                if (cnt[s] < KP_FULL) begin
                                    kp_we[s]                 <= 1'b1;
                                    kp_addr[s*KP_AW +: KP_AW] <= cnt[s][KP_AW-1:0];
                                    cnt[s]                   <= cnt[s] + (KP_AW+1)'(1);
                                end else begin
                                    kp_ovf[s] <= 1'b1;
                                end
                            end
                        end
                        if (cur_col != COL_LAST) cur_col <= cur_col + COL_W'(1);
                    end
                    S_UPDATE: begin
                        cur_col <= COL_FIRST;
                        if (row_addr != ROW_LAST) row_addr <= row_addr + ROW_W'(1);
                    end
                    S_DONE:  row_addr <= '0;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypoint_scan_ctrl.sv
// Self-checking bench: per-cycle schedule built from the scan rules, compared every cycle.
module tb_keypoint_scan_ctrl;

    localparam int W = 8, H = 6, NS = 2, D = 4, RW = 3, CW = 3, AW = 2;

    logic clk = 0, rst_n = 0, start = 0, abort = 0;
    logic busy, done, buffer_we;
    logic [RW-1:0]        row_addr;
    logic [CW-1:0]        cur_col;
    logic [NS-1:0]        detect_hit = '0, filter_ok = '0, kp_we, kp_ovf;
    logic [NS*AW-1:0]     kp_addr;
    logic [RW+CW-1:0]     kp_din;
    logic [NS*(AW+1)-1:0] kp_count;

    keypoint_scan_ctrl #(.IMG_W(W), .IMG_H(H), .N_SCALE(NS), .KP_DEPTH(D),
                         .ROW_W(RW), .COL_W(CW), .KP_AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .busy(busy),
        .done(done), .row_addr(row_addr), .buffer_we(buffer_we), .cur_col(cur_col),
        .detect_hit(detect_hit), .filter_ok(filter_ok), .kp_we(kp_we),
        .kp_addr(kp_addr), .kp_din(kp_din), .kp_count(kp_count), .kp_ovf(kp_ovf));

    always #5 clk = ~clk;

    typedef struct {
        logic busy, bwe, done, filt, st, ab;
        logic [2:0] row, col, cnt0, cnt1;
        logic [1:0] dh, fo, we, a0, a1, ovf;
        logic [5:0] din;
    } rec_t;

    rec_t q[$];
    rec_t cur;
    logic exp_valid = 0;
    int   errors = 0, checks = 0;

    logic [1:0] hit [0:7][0:7];
    logic [1:0] flt [0:7][0:7];
    logic [1:0] pw, pa0, pa1, mo;
    logic [5:0] pdin;
    int         mc [2];

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endfunction

    function automatic void emit(logic b, logic bwe, logic dn, logic f,
                                 logic [2:0] row, logic [2:0] col,
                                 logic [1:0] dh, logic [1:0] fo);
        rec_t r;
        r.busy = b; r.bwe = bwe; r.done = dn; r.filt = f; r.row = row; r.col = col;
        r.dh = dh; r.fo = fo; r.we = pw; r.a0 = pa0; r.a1 = pa1; r.din = pdin;
        r.cnt0 = 3'(mc[0]); r.cnt1 = 3'(mc[1]); r.ovf = mo; r.ab = 0;
        r.st = b ? 1'($urandom_range(0, 1)) : 1'b0;
        q.push_back(r);
        pw = '0;
    endfunction

    // Expected cycle stream of one frame: 2 prime cycles, 1 or 2 cycles per
    // column, UPDATE+BUFFER per row (last row goes UPDATE->DONE), then IDLE.
    function automatic void build_frame();
        q.delete(); pw = '0; mo = '0; mc[0] = 0; mc[1] = 0;
        emit(1, 1, 0, 0, 3'd0, 3'd1, 2'($urandom), 2'($urandom));
        emit(1, 1, 0, 0, 3'd1, 3'd1, 2'($urandom), 2'($urandom));
        for (int r = 2; r <= H - 1; r++) begin
            for (int c = 1; c <= W - 2; c++) begin
                if (hit[r][c] != 0) begin
                    emit(1, 0, 0, 0, 3'(r), 3'(c), hit[r][c], 2'($urandom));
                    emit(1, 0, 0, 1, 3'(r), 3'(c), 2'($urandom), flt[r][c]);
                    for (int s = 0; s < NS; s++) begin
                        if (hit[r][c][s] && flt[r][c][s]) begin
                            if (mc[s] < D) begin
                                pw[s] = 1'b1;
                                if (s == 0) pa0 = 2'(mc[0]); else pa1 = 2'(mc[1]);
                                pdin = {3'(r - 1), 3'(c)};
                                mc[s]++;
                            end else mo[s] = 1'b1;
                        end
                    end
                end else
                    emit(1, 0, 0, 0, 3'(r), 3'(c), 2'b00, 2'($urandom));
            end
            emit(1, 0, 0, 0, 3'(r), 3'(W - 2), 2'($urandom), 2'($urandom));
            if (r < H - 1) emit(1, 1, 0, 0, 3'(r + 1), 3'd1, 2'($urandom), 2'($urandom));
            else           emit(1, 0, 1, 0, 3'(r), 3'd1, 2'($urandom), 2'($urandom));
        end
        emit(0, 0, 0, 0, 3'd0, 3'd1, 2'b00, 2'b00);
    endfunction

    function automatic void clear_map();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                hit[r][c] = '0; flt[r][c] = '0;
            end
    endfunction

    // Abort at record idx: no write from that FILTER, idle afterwards, counts kept.
    function automatic void apply_abort(int idx);
        rec_t r;
        q[idx].ab = 1'b1;
        while (q.size() > idx + 1) void'(q.pop_back());
        r = q[idx];
        r.busy = 0; r.bwe = 0; r.done = 0; r.filt = 0; r.row = 0; r.col = 1;
        r.we = 0; r.st = 0; r.ab = 0; r.dh = 0; r.fo = 0;
        q.push_back(r);
    endfunction

    task automatic run_q(input int limit);
        start = 1;
        @(posedge clk); #1;
        for (int i = 0; i < q.size() && i < limit; i++) begin
            cur = q[i];
            detect_hit = cur.dh; filter_ok = cur.fo; start = cur.st; abort = cur.ab;
            exp_valid = 1;
            @(posedge clk); #1;
        end
        exp_valid = 0; start = 0; abort = 0; detect_hit = 0; filter_ok = 0;
    endtask

    always @(negedge clk) if (exp_valid) begin
        chk("busy", 32'(busy), 32'(cur.busy));
        chk("done", 32'(done), 32'(cur.done));
        chk("buffer_we", 32'(buffer_we), 32'(cur.bwe));
        chk("row_addr", 32'(row_addr), 32'(cur.row));
        chk("cur_col", 32'(cur_col), 32'(cur.col));
        chk("kp_we", 32'(kp_we), 32'(cur.we));
        chk("kp_count", 32'(kp_count), 32'({cur.cnt1, cur.cnt0}));
        chk("kp_ovf", 32'(kp_ovf), 32'(cur.ovf));
        if (cur.we[0]) chk("kp_addr0", 32'(kp_addr[1:0]), 32'(cur.a0));
        if (cur.we[1]) chk("kp_addr1", 32'(kp_addr[3:2]), 32'(cur.a1));
        if (cur.we != 0) chk("kp_din", 32'(kp_din), 32'(cur.din));
    end

    task automatic chk_reset_vals();
        chk("rst_busy", 32'(busy), 0);      chk("rst_done", 32'(done), 0);
        chk("rst_row", 32'(row_addr), 0);   chk("rst_col", 32'(cur_col), 1);
        chk("rst_bwe", 32'(buffer_we), 0);  chk("rst_we", 32'(kp_we), 0);
        chk("rst_addr", 32'(kp_addr), 0);   chk("rst_din", 32'(kp_din), 0);
        chk("rst_count", 32'(kp_count), 0); chk("rst_ovf", 32'(kp_ovf), 0);
    endtask

    initial begin
        int idx;
        #12; chk_reset_vals();
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;

        // empty frame: timing only
        clear_map(); build_frame();
        chk("model_len", 32'(q.size()), 35);
        idx = -1;
        foreach (q[i]) if (q[i].done) idx = i;
        chk("model_done_idx", 32'(idx), 33);   // 2 prime + 3 rows of 8 + last row of 7
        run_q(1000);

        // single valid hit, scale 0, centre row 2 col 3
        clear_map(); hit[3][3] = 2'b01; flt[3][3] = 2'b01; build_frame();
        foreach (q[i]) if (q[i].we != 0) chk("model_din", 32'(q[i].din), 32'(6'b010_011));
        run_q(1000);
        chk("t2_count", 32'(kp_count), 32'(6'b000_001));

        // both scales hit, only scale 1 passes the filter
        clear_map(); hit[2][4] = 2'b11; flt[2][4] = 2'b10; build_frame();
        chk("model_len_hit", 32'(q.size()), 36);
        run_q(1000);
        chk("t3_count", 32'(kp_count), 32'(6'b001_000));

        // scale 0 overflow after 4 entries
        clear_map();
        for (int c = 1; c <= 6; c++) begin hit[2][c] = 2'b01; flt[2][c] = 2'b01; end
        build_frame(); run_q(1000);
        chk("t4_count", 32'(kp_count), 32'(6'b000_100));
        chk("t4_ovf", 32'(kp_ovf), 32'(2'b01));

        // start and abort together in IDLE: stays idle, counts kept
        start = 1; abort = 1; @(posedge clk); #1; start = 0; abort = 0;
        chk("sa_busy", 32'(busy), 0);
        chk("sa_count", 32'(kp_count), 32'(6'b000_100));

        // abort inside FILTER with a valid hit
        clear_map(); hit[2][2] = 2'b01; flt[2][2] = 2'b01;
        hit[3][3] = 2'b11; flt[3][3] = 2'b11; build_frame();
        idx = -1;
        foreach (q[i]) if (q[i].filt && q[i].row == 3 && idx < 0) idx = i;
        apply_abort(idx);
        run_q(1000);
        chk("t5_count", 32'(kp_count), 32'(6'b000_001));
        clear_map(); build_frame(); run_q(1000);

        // random frames
        for (int f = 0; f < 6; f++) begin
            clear_map();
            for (int r = 2; r <= H - 1; r++)
                for (int c = 1; c <= W - 2; c++) begin
                    hit[r][c] = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
                    flt[r][c] = 2'($urandom);
                end
            build_frame(); run_q(1000);
        end

        // asynchronous reset mid-row, then a clean rescan
        clear_map(); hit[2][2] = 2'b01; flt[2][2] = 2'b01; build_frame();
        run_q(12);
        #2 rst_n = 0; #1;
        chk_reset_vals();
        @(posedge clk); #1 rst_n = 1;
        @(posedge clk); #1;
        build_frame(); run_q(1000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
